// File: rtl/puneh_flow_unit.sv
// puneh_flow_unit: program-flow and addressing stage of the PUNEH processor.
// Holds PC, page offset (OF), indirect register (IN) and status register (SR).
// Drives the memory address bus and returns the skip condition to the controller.
module puneh_flow_unit #(
  parameter int ADDR_W = 16,
  parameter int OF_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       inst,
  input  logic [15:0]       mem_rdata,
  input  logic [3:0]        aru_flags,
  input  logic [3:0]        lgu_flags,
  input  logic              ldPC,
  input  logic              INC1,
  input  logic              INC2,
  input  logic              selINC_PC,
  input  logic              selMEM_PC,
  input  logic              selIMM_PC,
  input  logic              selLOP,
  input  logic              ldOF,
  input  logic              selPC_OF,
  input  logic              selIMM_OF,
  input  logic              conOF,
  input  logic              ldIN,
  input  logic              selMEM_IN,
  input  logic              selINC_IN,
  input  logic              selPC_ADR,
  input  logic              selIR_ADR,
  input  logic              selIN_ADR,
  input  logic [3:0]        ldSR,
  input  logic              selSET_SR,
  input  logic              selARU_SR,
  input  logic              selLGU_SR,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] in_reg,
  output logic [OF_W-1:0]   of_reg,
  output logic [3:0]        sr,
  output logic              enSKP
);

  // Architectural state
  logic [15:0] r_pc;
  logic [15:0] r_in;
  logic [3:0]  r_of;
  logic [3:0]  r_sr;

  // Next-state and datapath wires
  logic [15:0] w_pc_nxt;
  logic [15:0] w_in_nxt;
  logic [3:0]  w_of_nxt;
  logic [3:0]  w_sr_nxt;
  logic [15:0] w_tgt;
  logic [15:0] w_lop_off;
  logic [15:0] w_addr;
  logic [3:0]  w_skp_hit;
  logic        w_skp;

  // Page target: optionally splice the page offset above the 12-bit field
  always_comb begin
    w_tgt = {4'h0, inst[11:0]};
    if (conOF) begin
      w_tgt = {r_of, inst[11:0]};
    end else begin
      w_tgt = {4'h0, inst[11:0]};
    end
  end

  // Sign-extended 5-bit loop displacement
  always_comb begin
    w_lop_off = {{11{inst[4]}}, inst[4:0]};
  end

  // PC next-state: taken skip overrides, then ldPC with source priority
  always_comb begin
    w_pc_nxt = r_pc;
    if (INC2) begin
      w_pc_nxt = r_pc + 16'd2;
    end else if (!ldPC) begin
      w_pc_nxt = r_pc;
    end else if (selMEM_PC) begin
      w_pc_nxt = mem_rdata;
    end else if (selLOP) begin
      w_pc_nxt = r_pc + w_lop_off;
    end else if (selIMM_PC) begin
      w_pc_nxt = w_tgt;
    end else if (selINC_PC && INC1) begin
      w_pc_nxt = r_pc + 16'd1;
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // OF next-state: immediate nibble or current PC page
  always_comb begin
    w_of_nxt = r_of;
    if (!ldOF) begin
      w_of_nxt = r_of;
    end else if (selIMM_OF) begin
      w_of_nxt = inst[3:0];
    end else if (selPC_OF) begin
      w_of_nxt = r_pc[15:12];
    end else begin
      w_of_nxt = r_of;
    end
  end

  // IN next-state: memory word, or memory word plus one for auto-increment
  always_comb begin
    w_in_nxt = r_in;
    if (!ldIN) begin
      w_in_nxt = r_in;
    end else if (selMEM_IN) begin
      w_in_nxt = mem_rdata;
    end else if (selINC_IN) begin
      w_in_nxt = mem_rdata + 16'd1;
    end else begin
      w_in_nxt = r_in;
    end
  end

  // SR next-state: per-bit enables, source priority SET > ARU > LGU
  always_comb begin
    w_sr_nxt = r_sr;
    for (int i = 0; i < 4; i++) begin
      if (!ldSR[i]) begin
        w_sr_nxt[i] = r_sr[i];
      end else if (selSET_SR) begin
        w_sr_nxt[i] = inst[i];
      end else if (selARU_SR) begin
        w_sr_nxt[i] = aru_flags[i];
      end else if (selLGU_SR) begin
        w_sr_nxt[i] = lgu_flags[i];
      end else begin
        w_sr_nxt[i] = r_sr[i];
      end
    end
  end

  // State registers; loads during reset are discarded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= 16'h0000;
      r_of <= 4'h0;
      r_in <= 16'h0000;
      r_sr <= 4'h0;
    end else begin
      r_pc <= w_pc_nxt;
      r_of <= w_of_nxt;
      r_in <= w_in_nxt;
      r_sr <= w_sr_nxt;
    end
  end

  // Address mux, priority PC > IN > IR; idles at zero
  always_comb begin
    w_addr = 16'h0000;
    if (selPC_ADR) begin
      w_addr = r_pc;
    end else if (selIN_ADR) begin
      w_addr = r_in;
    end else if (selIR_ADR) begin
      w_addr = w_tgt;
    end else begin
      w_addr = 16'h0000;
    end
  end

  // Skip condition: any masked flag set, inverted by the polarity bit
  always_comb begin
    w_skp_hit = r_sr & inst[3:0];
    w_skp     = (|w_skp_hit) ^ inst[4];
  end

  assign addr   = w_addr;
  assign pc     = r_pc;
  assign in_reg = r_in;
  assign of_reg = r_of;
  assign sr     = r_sr;
  assign enSKP  = w_skp;

endmodule

// File: tb/tb_puneh_flow_unit.sv
// Self-checking bench for puneh_flow_unit: directed scenarios plus random
// stimulus compared against an arithmetic reference model.
module tb_puneh_flow_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inst, mem_rdata;
  logic [3:0]  aru_flags, lgu_flags, ldSR;
  logic ldPC, INC1, INC2, selINC_PC, selMEM_PC, selIMM_PC, selLOP;
  logic ldOF, selPC_OF, selIMM_OF, conOF;
  logic ldIN, selMEM_IN, selINC_IN;
  logic selPC_ADR, selIR_ADR, selIN_ADR;
  logic selSET_SR, selARU_SR, selLGU_SR;
  logic [15:0] addr, pc, in_reg;
  logic [3:0]  of_reg, sr;
  logic        enSKP;

  int checks = 0;
  int failures = 0;
  // reference model state (plain integers)
  int m_pc, m_of, m_in, m_sr;

  always #5 clk = ~clk;

  puneh_flow_unit dut (
    .clk(clk), .rst(rst), .inst(inst), .mem_rdata(mem_rdata),
    .aru_flags(aru_flags), .lgu_flags(lgu_flags),
    .ldPC(ldPC), .INC1(INC1), .INC2(INC2), .selINC_PC(selINC_PC),
    .selMEM_PC(selMEM_PC), .selIMM_PC(selIMM_PC), .selLOP(selLOP),
    .ldOF(ldOF), .selPC_OF(selPC_OF), .selIMM_OF(selIMM_OF), .conOF(conOF),
    .ldIN(ldIN), .selMEM_IN(selMEM_IN), .selINC_IN(selINC_IN),
    .selPC_ADR(selPC_ADR), .selIR_ADR(selIR_ADR), .selIN_ADR(selIN_ADR),
    .ldSR(ldSR), .selSET_SR(selSET_SR), .selARU_SR(selARU_SR), .selLGU_SR(selLGU_SR),
    .addr(addr), .pc(pc), .in_reg(in_reg), .of_reg(of_reg), .sr(sr), .enSKP(enSKP)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int m_tgt();
    int low;
    low = int'(inst) % 4096;
    return conOF ? (m_of * 4096 + low) : low;
  endfunction

  function automatic int m_addr();
    if (selPC_ADR) return m_pc;
    if (selIN_ADR) return m_in;
    if (selIR_ADR) return m_tgt();
    return 0;
  endfunction

  function automatic int m_skip();
    int mask, pol;
    mask = int'(inst) % 16;
    pol  = (int'(inst) / 16) % 2;
    return (((m_sr & mask) != 0) ? 1 : 0) ^ pol;
  endfunction

  // advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    int n_pc, n_of, n_in, n_sr, disp, bitv;
    n_pc = m_pc; n_of = m_of; n_in = m_in; n_sr = m_sr;
    disp = int'(inst) % 32;
    if (disp >= 16) disp = disp - 32;
    if (INC2)                     n_pc = (m_pc + 2) % 65536;
    else if (ldPC && selMEM_PC)   n_pc = int'(mem_rdata);
    else if (ldPC && selLOP)      n_pc = (m_pc + disp + 65536) % 65536;
    else if (ldPC && selIMM_PC)   n_pc = m_tgt();
    else if (ldPC && selINC_PC && INC1) n_pc = (m_pc + 1) % 65536;
    if (ldOF && selIMM_OF)        n_of = int'(inst) % 16;
    else if (ldOF && selPC_OF)    n_of = m_pc / 4096;
    if (ldIN && selMEM_IN)        n_in = int'(mem_rdata);
    else if (ldIN && selINC_IN)   n_in = (int'(mem_rdata) + 1) % 65536;
    for (int i = 0; i < 4; i++) begin
      if (ldSR[i] && (selSET_SR || selARU_SR || selLGU_SR)) begin
        bitv = selSET_SR ? int'(inst[i]) : (selARU_SR ? int'(aru_flags[i]) : int'(lgu_flags[i]));
        n_sr = bitv ? (n_sr | (1 << i)) : (n_sr & ~(1 << i));
      end
    end
    m_pc = n_pc; m_of = n_of; m_in = n_in; m_sr = n_sr;
  endtask

  task automatic check_all(input string ctx);
    check_val({ctx, ".pc"},    pc,            16'(m_pc));
    check_val({ctx, ".of"},    {12'h000, of_reg}, 16'(m_of));
    check_val({ctx, ".in"},    in_reg,        16'(m_in));
    check_val({ctx, ".sr"},    {12'h000, sr}, 16'(m_sr));
    check_val({ctx, ".addr"},  addr,          16'(m_addr()));
    check_val({ctx, ".enSKP"}, {15'h0000, enSKP}, 16'(m_skip()));
  endtask

  task automatic idle();
    inst = 16'h0000; mem_rdata = 16'h0000; aru_flags = 4'h0; lgu_flags = 4'h0; ldSR = 4'h0;
    ldPC = 1'b0; INC1 = 1'b0; INC2 = 1'b0; selINC_PC = 1'b0; selMEM_PC = 1'b0;
    selIMM_PC = 1'b0; selLOP = 1'b0; ldOF = 1'b0; selPC_OF = 1'b0; selIMM_OF = 1'b0;
    conOF = 1'b0; ldIN = 1'b0; selMEM_IN = 1'b0; selINC_IN = 1'b0; selPC_ADR = 1'b0;
    selIR_ADR = 1'b0; selIN_ADR = 1'b0; selSET_SR = 1'b0; selARU_SR = 1'b0; selLGU_SR = 1'b0;
  endtask

  // called at a negedge with inputs set: check pre-edge view, clock, update model
  task automatic cycle(input string ctx);
    #1 check_all(ctx);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic load_pc(input logic [15:0] v);
    idle(); ldPC = 1'b1; selMEM_PC = 1'b1; mem_rdata = v;
    cycle("ldpc");
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    m_pc = 0; m_of = 0; m_in = 0; m_sr = 0;
    @(negedge clk); @(negedge clk);
    #1 check_val("reset_pc", pc, 16'h0000);
    check_val("reset_sr", {12'h000, sr}, 16'h0000);
    check_val("reset_skp", {15'h0000, enSKP}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // asynchronous reset mid-count
    load_pc(16'h0123);
    check_val("pc_0123", pc, 16'h0123);
    selPC_ADR = 1'b1; ldPC = 1'b1; selINC_PC = 1'b1; INC1 = 1'b1;
    #2 rst = 1'b0;
    #1 check_val("async_pc", pc, 16'h0000);
    check_val("async_of", {12'h000, of_reg}, 16'h0000);
    check_val("async_in", in_reg, 16'h0000);
    check_val("async_sr", {12'h000, sr}, 16'h0000);
    check_val("async_addr", addr, 16'h0000);
    m_pc = 0; m_of = 0; m_in = 0; m_sr = 0;
    @(negedge clk);
    rst = 1'b1;
    idle();

    // increment and wrap
    load_pc(16'hFFFE);
    ldPC = 1'b1; selINC_PC = 1'b1; INC1 = 1'b1;
    cycle("inc1");
    check_val("inc_ffff", pc, 16'hFFFF);
    cycle("inc2");
    check_val("inc_wrap", pc, 16'h0000);
    load_pc(16'hFFFF);
    INC2 = 1'b1;
    cycle("skip2");
    check_val("inc2_wrap", pc, 16'h0001);

    // paged jump
    idle(); ldOF = 1'b1; selIMM_OF = 1'b1; inst = 16'h000A;
    cycle("of_imm");
    check_val("of_a", {12'h000, of_reg}, 16'h000A);
    idle(); inst = 16'hC345; conOF = 1'b1; selIMM_PC = 1'b1; ldPC = 1'b1;
    cycle("jmp_page");
    check_val("jmp_a345", pc, 16'hA345);
    conOF = 1'b0;
    cycle("jmp_zero");
    check_val("jmp_0345", pc, 16'h0345);

    // loop branch
    load_pc(16'h0010);
    ldPC = 1'b1; selLOP = 1'b1; inst = 16'h001E;
    cycle("lop_neg");
    check_val("lop_000e", pc, 16'h000E);
    inst = 16'h0003;
    cycle("lop_pos");
    check_val("lop_0011", pc, 16'h0011);

    // indirect addressing
    idle(); ldIN = 1'b1; selINC_IN = 1'b1; mem_rdata = 16'h7FFF;
    cycle("in_inc");
    idle(); selIN_ADR = 1'b1;
    #1 check_val("in_8000", in_reg, 16'h8000);
    check_val("addr_8000", addr, 16'h8000);
    ldIN = 1'b1; selINC_IN = 1'b1; mem_rdata = 16'hFFFF;
    cycle("in_wrap");
    check_val("in_wrap0", in_reg, 16'h0000);

    // SR and skip (start from cleared SR)
    load_pc(16'h0000);
    idle(); ldSR = 4'b1111; selSET_SR = 1'b1; inst = 16'h0000;
    cycle("sr_clr");
    idle(); ldSR = 4'b0001; selARU_SR = 1'b1; aru_flags = 4'b0001; inst = 16'h0001;
    #1 check_val("sr_before", {12'h000, sr}, 16'h0000);
    check_val("skp_before", {15'h0000, enSKP}, 16'h0000);
    cycle("sr_aru");
    idle(); inst = 16'h0001;
    #1 check_val("sr_after", {12'h000, sr}, 16'h0001);
    check_val("skp_1", {15'h0000, enSKP}, 16'h0001);
    inst = 16'h0011;
    #1 check_val("skp_pol", {15'h0000, enSKP}, 16'h0000);
    idle(); ldSR = 4'b1100; selSET_SR = 1'b1; inst = 16'h0008;
    cycle("sr_set");
    check_val("sr_1001", {12'h000, sr}, 16'h0009);
    idle(); ldSR = 4'b0000; selSET_SR = 1'b1; selARU_SR = 1'b1; selLGU_SR = 1'b1;
    inst = 16'h0006; aru_flags = 4'b0110; lgu_flags = 4'b0110;
    cycle("sr_hold");
    check_val("sr_hold", {12'h000, sr}, 16'h0009);
    idle(); inst = 16'h0010;
    #1 check_val("skp_mask0", {15'h0000, enSKP}, 16'h0001);

    // randomized phase against the model
    for (int n = 0; n < 400; n++) begin
      inst = 16'($urandom); mem_rdata = 16'($urandom);
      aru_flags = 4'($urandom); lgu_flags = 4'($urandom); ldSR = 4'($urandom);
      ldPC = 1'($urandom); INC1 = 1'($urandom); INC2 = ($urandom_range(0, 7) == 0);
      selINC_PC = 1'($urandom); selMEM_PC = ($urandom_range(0, 3) == 0);
      selIMM_PC = 1'($urandom); selLOP = ($urandom_range(0, 2) == 0);
      ldOF = 1'($urandom); selPC_OF = 1'($urandom); selIMM_OF = 1'($urandom); conOF = 1'($urandom);
      ldIN = 1'($urandom); selMEM_IN = 1'($urandom); selINC_IN = 1'($urandom);
      selPC_ADR = 1'($urandom); selIR_ADR = 1'($urandom); selIN_ADR = 1'($urandom);
      selSET_SR = 1'($urandom); selARU_SR = 1'($urandom); selLGU_SR = 1'($urandom);
      cycle("rand");
    end
    #1 check_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/puneh_flow_unit.md
# puneh_flow_unit

Program-flow and addressing datapath stage for the PUNEH processor. It sits directly downstream of the PUNEH controller and consumes its sequencing strobes (`ldPC`, `INC1`/`INC2`, `ldOF`, `ldIN`, `ldSR`, address selects). It holds the PC, the page offset (OF), the indirect register (IN) and the 4-bit status register (SR). It drives the memory address bus and returns the skip condition `enSKP` to the controller.

## Interface
- ADDR_W, 16, PC / address-bus width (fixed at 16 in this revision)
- OF_W, 4, page-offset register width; the page field is addr[15:12]
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (rst = 0 resets)
- inst  in  16  current instruction register contents
- mem_rdata  in  16  memory read data
- aru_flags, lgu_flags  in  4 each  flag vectors {V,C,N,Z} from the ARU and the LGU
- ldPC, INC1, INC2, selINC_PC, selMEM_PC, selIMM_PC, selLOP  in  1 each  PC control
- ldOF, selPC_OF, selIMM_OF, conOF  in  1 each  offset control
- ldIN, selMEM_IN, selINC_IN  in  1 each  IN control
- selPC_ADR, selIR_ADR, selIN_ADR  in  1 each  address select
- ldSR  in  4  per-flag SR write enables
- selSET_SR, selARU_SR, selLGU_SR  in  1 each  SR source select
- addr  out  16  memory address (combinational)
- pc, in_reg  out  16 each  register values
- of_reg  out  4  page-offset register value
- sr  out  4  status {V,C,N,Z}
- enSKP  out  1  skip condition (combinational)

## Operation
- Reset: pc = 0, of_reg = 0, in_reg = 0, sr = 0. With no address select active, addr = 0 and enSKP = 0.
- Page target `tgt`:
  - conOF = 1: tgt = {of_reg, inst[11:0]}
  - conOF = 0: tgt = {4'h0, inst[11:0]}
- PC update rules, first match wins (priority applies only if the controller violates one-hot):
  1. INC2 = 1 loads pc+2 whether or not ldPC is set. This is the taken-skip case.
  2. If ldPC = 0, pc holds.
  3. selMEM_PC: pc = mem_rdata.
  4. selLOP: pc = pc + sign-extended inst[4:0].
  5. selIMM_PC: pc = tgt.
  6. selINC_PC with INC1: pc = pc+1.
  7. ldPC with no valid source: pc holds.
- All PC arithmetic is modulo 2^16: 16'hFFFF+1 = 0, 16'hFFFF+2 = 1, and 0 + (-1) = 16'hFFFF.
- OF update on ldOF:
  - selIMM_OF: of_reg = inst[3:0]
  - selPC_OF: of_reg = pc[15:12]
  - neither: of_reg holds
- IN update on ldIN:
  - selMEM_IN: in_reg = mem_rdata
  - selINC_IN: in_reg = mem_rdata+1, with wrap
  - neither: in_reg holds
- Address mux, priority PC > IN > IR:
  - selPC_ADR: addr = pc
  - selIN_ADR: addr = in_reg
  - selIR_ADR: addr = tgt
  - none: addr = 0
- SR update, per bit i where ldSR[i] = 1, priority SET > ARU > LGU; bits with ldSR[i] = 0 hold:
  - selSET_SR: sr[i] = inst[i]
  - selARU_SR: sr[i] = aru_flags[i]
  - selLGU_SR: sr[i] = lgu_flags[i]
  - ldSR[i] = 1 with no source select: sr[i] holds
- Skip condition: mask = inst[3:0], pol = inst[4]; enSKP = (|(sr & mask)) ^ pol.
  - mask = 0 gives enSKP = pol (unconditional skip or no-skip).
  - enSKP is evaluated regardless of opcode; the controller qualifies it.

## Timing
- All registers update on the rising clk edge. addr, pc, of_reg, in_reg, sr and enSKP are valid from the register outputs in the same cycle.
- A flag written at edge N is seen by enSKP in the cycle after edge N. There is no SR bypass.
- A PC load at edge N appears on addr (with selPC_ADR) in the cycle after edge N. This matches the controller's 2- to 3-cycle fetch/exec1/exec2 sequence.
- ldOF and ldPC in the same cycle: the PC source uses the old of_reg, and selPC_OF uses the old pc.
- Asserting rst mid-instruction clears all registers immediately (asynchronous). Release is synchronous to clk: the first load occurs on the first edge with rst = 1.
- Register loads in the reset cycle are discarded.

## Test plan
- Reset: pulse rst = 0 mid-count with pc = 16'h0123 → pc, of_reg, in_reg, sr read 0 immediately; with selPC_ADR = 1, addr = 0.
- Increment and wrap:
  - pc = 16'hFFFE, ldPC+selINC_PC+INC1 for two cycles → 16'hFFFF, then 16'h0000.
  - INC2 alone from pc = 16'hFFFF → pc = 16'h0001.
- Paged jump: set of_reg = 4'hA via selIMM_OF (inst[3:0] = 4'hA), then inst = 16'hC345 with conOF+selIMM_PC+ldPC → pc = 16'hA345; with conOF = 0 → pc = 16'h0345.
- Loop branch: pc = 16'h0010, inst[4:0] = 5'b11110, selLOP+ldPC → pc = 16'h000E; inst[4:0] = 5'b00011 → pc = 16'h0011.
- Indirect addressing: mem_rdata = 16'h7FFF with ldIN+selINC_IN → in_reg = 16'h8000; selIN_ADR → addr = 16'h8000; same with mem_rdata = 16'hFFFF → in_reg = 0.
- SR and skip:
  - ldSR = 4'b0001, selARU_SR, aru_flags = 4'b0001 → sr = 4'b0001 after the edge (not before); inst[4:0] = 5'b00001 → enSKP = 1; 5'b10001 → enSKP = 0.
  - SET with ldSR = 4'b1100, inst[3:0] = 4'b1000 → sr = 4'b1001.
  - ldSR = 4'b0000 with all sources active → sr unchanged.
